// File: rtl/edge_config_loader_pkg.sv
// Shared types and constants for the edge configuration loader: controller stage
// encodings, boundary codes, the cfg word layout and the loader FSM states.
package edge_config_loader_pkg;

  localparam int STAGE_WIDTH = 3;
  localparam logic [STAGE_WIDTH-1:0] STAGE_IDLE               = 3'd0;
  localparam logic [STAGE_WIDTH-1:0] STAGE_PARAMETERS_LOADING = 3'd1;
  localparam logic [STAGE_WIDTH-1:0] STAGE_WRITE_TO_MEM       = 3'd2;
  localparam logic [STAGE_WIDTH-1:0] STAGE_COMPUTE            = 3'd3;

  localparam logic [1:0] BC_NONE     = 2'd0;
  localparam logic [1:0] BC_BOUNDARY = 2'd1;
  localparam logic [1:0] BC_ABSENT   = 2'd2;

  localparam int DEF_MAX_WEIGHT     = 2;
  localparam int DEF_LINK_BIT_WIDTH = $clog2(DEF_MAX_WEIGHT + 1);

  typedef struct packed {
    logic [DEF_LINK_BIT_WIDTH-1:0] weight;
    logic [1:0]                    bc;
  } cfg_word_t;

  typedef enum logic [1:0] {LD_IDLE, LD_LOAD, LD_DONE} ld_state_t;

endpackage

// File: rtl/edge_config_loader_if.sv
// Valid/ready stream carrying {weight, boundary_condition} config words.
interface edge_config_loader_if #(
    parameter int DATA_W = 4
);
    logic              cfg_valid;
    logic              cfg_ready;
    logic [DATA_W-1:0] cfg_data;

    modport master (output cfg_valid, output cfg_data, input cfg_ready);
    modport slave  (input cfg_valid, input cfg_data, output cfg_ready);
endinterface

// File: rtl/edge_cfg_table.sv
// Per-context edge table: one sanitising write port, registered full-context read.
// Entries reset to disabled (weight 0, boundary absent).
module edge_cfg_table
    import edge_config_loader_pkg::*;
#(
    parameter  int NUM_LINKS    = 8,
    parameter  int NUM_CONTEXTS = 2,
    parameter  int MAX_WEIGHT   = 2,
    localparam int LBW          = $clog2(MAX_WEIGHT + 1),
    localparam int CTX_W        = (NUM_CONTEXTS > 1) ? $clog2(NUM_CONTEXTS) : 1,
    localparam int LIDX_W       = (NUM_LINKS > 1) ? $clog2(NUM_LINKS) : 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            we,
    input  logic [CTX_W-1:0]                wr_ctx,
    input  logic [LIDX_W-1:0]               wr_link,
    input  logic [LBW-1:0]                  wr_weight,
    input  logic [1:0]                      wr_bc,
    input  logic [CTX_W-1:0]                rd_ctx,
    output logic [NUM_LINKS-1:0][LBW-1:0]   weight,
    output logic [NUM_LINKS-1:0][1:0]       bc
);

    logic [LBW-1:0] w_san;
    logic [1:0]     bc_san;

    // Absent edges never carry a weight, whatever the word said.
    always_comb begin
        bc_san = (wr_bc == 2'd3) ? BC_ABSENT : wr_bc;
        w_san  = (wr_weight > LBW'(MAX_WEIGHT)) ? LBW'(MAX_WEIGHT) : wr_weight;
        if (bc_san == BC_ABSENT) w_san = '0;
    end

    for (genvar l = 0; l < NUM_LINKS; l++) begin : g_link
        logic [NUM_CONTEXTS-1:0][LBW-1:0] w_mem;
        logic [NUM_CONTEXTS-1:0][1:0]     bc_mem;
        logic [LBW-1:0]                   w_q;
        logic [1:0]                       bc_q;

        always_ff @(posedge clk) begin
            if (reset) begin
                w_mem  <= '0;
                bc_mem <= {NUM_CONTEXTS{BC_ABSENT}};
                w_q    <= '0;
                bc_q   <= BC_ABSENT;
            end else begin
                if (we && wr_link == LIDX_W'(l)) begin
                    w_mem[wr_ctx]  <= w_san;
                    bc_mem[wr_ctx] <= bc_san;
                end
                w_q  <= w_mem[rd_ctx];
                bc_q <= bc_mem[rd_ctx];
            end
        end

        assign weight[l] = w_q;
        assign bc[l]     = bc_q;
    end

endmodule

// File: rtl/edge_config_loader.sv
// Loads per-edge config words for every context and drives the active context's
// weights/boundaries to the links. EDGE_CFG_CHECK_EN enables the sticky cfg_error check.
module edge_config_loader
    import edge_config_loader_pkg::*;
#(
    parameter  int NUM_LINKS      = 8,
    parameter  int MAX_WEIGHT     = 2,
    parameter  int NUM_CONTEXTS   = 2,
    localparam int LINK_BIT_WIDTH = $clog2(MAX_WEIGHT + 1),
    localparam int CTX_W          = (NUM_CONTEXTS > 1) ? $clog2(NUM_CONTEXTS) : 1,
    localparam int LIDX_W         = (NUM_LINKS > 1) ? $clog2(NUM_LINKS) : 1
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [STAGE_WIDTH-1:0]              global_stage,
    input  logic                                local_context_switch,
    edge_config_loader_if.slave                 cfg,
    output logic [NUM_LINKS*LINK_BIT_WIDTH-1:0] weight_out,
    output logic [NUM_LINKS*2-1:0]              boundary_condition_out,
    output logic [CTX_W-1:0]                    current_context,
    output logic                                load_done,
    output logic                                cfg_error
);

    ld_state_t               state;
    logic [STAGE_WIDTH-1:0]  stage, stage_prev;
    logic                    ready;
    logic [LIDX_W-1:0]       link_idx;
    logic [CTX_W-1:0]        ctx_idx;
    logic                    hs, last_word, load_start, load_abort, in_load_stage;
    logic [LINK_BIT_WIDTH-1:0] cfg_w;
    logic [1:0]              cfg_bc;

    assign cfg_w         = cfg.cfg_data[LINK_BIT_WIDTH+1:2];
    assign cfg_bc        = cfg.cfg_data[1:0];
    assign cfg.cfg_ready = ready;
    assign hs            = cfg.cfg_valid && ready;
    assign in_load_stage = (stage == STAGE_PARAMETERS_LOADING);
    assign last_word     = (link_idx == LIDX_W'(NUM_LINKS - 1)) &&
                           (ctx_idx == CTX_W'(NUM_CONTEXTS - 1));
    // DONE only restarts on a fresh entry into the loading stage.
    assign load_start    = ((state == LD_IDLE) && in_load_stage) ||
                           ((state == LD_DONE) && in_load_stage &&
                            (stage_prev != STAGE_PARAMETERS_LOADING));
    assign load_abort    = (state == LD_LOAD) && !(hs && last_word) && !in_load_stage;

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= LD_IDLE;
            stage           <= STAGE_IDLE;
            stage_prev      <= STAGE_IDLE;
            ready           <= 1'b0;
            load_done       <= 1'b0;
            link_idx        <= '0;
            ctx_idx         <= '0;
            current_context <= '0;
        end else begin
            stage      <= global_stage;
            stage_prev <= stage;
            if (stage == STAGE_WRITE_TO_MEM && !local_context_switch)
                current_context <= (current_context == CTX_W'(NUM_CONTEXTS - 1)) ?
                                   '0 : current_context + CTX_W'(1);
            if (load_start) begin
                state           <= LD_LOAD;
                ready           <= 1'b1;
                load_done       <= 1'b0;
                link_idx        <= '0;
                ctx_idx         <= '0;
                current_context <= '0;
            end else if (state == LD_LOAD) begin
                if (hs) begin
                    if (link_idx == LIDX_W'(NUM_LINKS - 1)) begin
                        link_idx <= '0;
                        ctx_idx  <= ctx_idx + CTX_W'(1);
                    end else begin
                        link_idx <= link_idx + LIDX_W'(1);
                    end
                end
                if (hs && last_word) begin
                    state     <= LD_DONE;
                    ready     <= 1'b0;
                    load_done <= 1'b1;
                end else if (load_abort) begin
                    state <= LD_IDLE;
                    ready <= 1'b0;
                end
            end
        end
    end

`ifdef EDGE_CFG_CHECK_EN
    logic bad_word;
    assign bad_word = (cfg_w > LINK_BIT_WIDTH'(MAX_WEIGHT)) || (cfg_bc == 2'd3) ||
                      ((cfg_w == '0) && (cfg_bc == BC_NONE || cfg_bc == BC_BOUNDARY));

    always_ff @(posedge clk) begin
        if (reset || load_start)              cfg_error <= 1'b0;
        else if ((hs && bad_word) || load_abort) cfg_error <= 1'b1;
    end
`else
    assign cfg_error = 1'b0;
`endif

    edge_cfg_table #(
        .NUM_LINKS   (NUM_LINKS),
        .NUM_CONTEXTS(NUM_CONTEXTS),
        .MAX_WEIGHT  (MAX_WEIGHT)
    ) u_table (
        .clk      (clk),
        .reset    (reset),
        .we       (hs),
        .wr_ctx   (ctx_idx),
        .wr_link  (link_idx),
        .wr_weight(cfg_w),
        .wr_bc    (cfg_bc),
        .rd_ctx   (current_context),
        .weight   (weight_out),
        .bc       (boundary_condition_out)
    );

endmodule

// File: tb/tb_edge_config_loader.sv
// Randomised self-checking bench for edge_config_loader against a table/word-count model.
module tb_edge_config_loader;
    import edge_config_loader_pkg::*;

    localparam int NL  = 8;
    localparam int NC  = 2;
    localparam int MW  = 2;
    localparam int LBW = $clog2(MW + 1);

    logic                   clk = 1'b0;
    logic                   reset;
    logic [STAGE_WIDTH-1:0] global_stage;
    logic                   local_context_switch;
    logic [NL*LBW-1:0]      weight_out;
    logic [NL*2-1:0]        boundary_condition_out;
    logic                   current_context;
    logic                   load_done;
    logic                   cfg_error;

    edge_config_loader_if #(.DATA_W(LBW + 2)) cfg_if ();

    edge_config_loader #(.NUM_LINKS(NL), .MAX_WEIGHT(MW), .NUM_CONTEXTS(NC)) dut (
        .clk                   (clk),
        .reset                 (reset),
        .global_stage          (global_stage),
        .local_context_switch  (local_context_switch),
        .cfg                   (cfg_if.slave),
        .weight_out            (weight_out),
        .boundary_condition_out(boundary_condition_out),
        .current_context       (current_context),
        .load_done             (load_done),
        .cfg_error             (cfg_error)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: table contents, words accepted in the current load, error flag,
    // and the context pointer as seen by the registered stage.
    int   mw [NC][NL];
    int   mbc[NC][NL];
    int   m_k;
    logic m_err;
    int   m_ctx, m_out;
    logic [STAGE_WIDTH-1:0] m_stage;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset_table();
        for (int c = 0; c < NC; c++)
            for (int l = 0; l < NL; l++) begin
                mw[c][l]  = 0;
                mbc[c][l] = 2;
            end
    endfunction

    function automatic void model_store(input int w, input int bc);
        int c, l, sb, sw;
        c  = m_k / NL;
        l  = m_k % NL;
        sb = (bc == 3) ? 2 : bc;
        sw = (sb == 2) ? 0 : ((w > MW) ? MW : w);
        mw[c][l]  = sw;
        mbc[c][l] = sb;
        if (w > MW || bc == 3 || (w == 0 && bc < 2)) m_err = 1'b1;
        m_k++;
    endfunction

    function automatic logic [63:0] exp_w(input int c);
        logic [63:0] v = '0;
        for (int l = 0; l < NL; l++) v[l*LBW +: LBW] = LBW'(mw[c][l]);
        return v;
    endfunction

    function automatic logic [63:0] exp_bc(input int c);
        logic [63:0] v = '0;
        for (int l = 0; l < NL; l++) v[l*2 +: 2] = 2'(mbc[c][l]);
        return v;
    endfunction

    function automatic logic exp_err();
`ifdef EDGE_CFG_CHECK_EN
        return m_err;
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk_outputs(input string tag, input int c);
        chk({tag, "_weight"}, 64'(weight_out), exp_w(c));
        chk({tag, "_bc"}, 64'(boundary_condition_out), exp_bc(c));
    endtask

    // mode 0: {w=i%3, bc=0}; mode 1: random; mode 2: random with an illegal {3,3} first.
    task automatic load(input int n, input int gap_max, input int mode);
        cfg_word_t cw;
        int w, bc, budget;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, gap_max)) begin
                cfg_if.cfg_valid = 1'b0;
                @(negedge clk);
            end
            if (mode == 0)                  begin w = i % 3; bc = 0; end
            else if (mode == 2 && i == 0)   begin w = 3; bc = 3; end
            else begin w = $urandom_range(0, 3); bc = $urandom_range(0, 3); end
            cw.weight = LBW'(w);
            cw.bc     = 2'(bc);
            cfg_if.cfg_valid = 1'b1;
            cfg_if.cfg_data  = cw;
            budget = 0;
            while (!cfg_if.cfg_ready && budget < 20) begin
                @(negedge clk);
                budget++;
            end
            if (budget >= 20) begin
                chk("ready_timeout", 64'(cfg_if.cfg_ready), 64'd1);
                cfg_if.cfg_valid = 1'b0;
                return;
            end
            @(negedge clk);
            model_store(w, bc);
            chk("load_done_progress", 64'(load_done), 64'(m_k == NL * NC));
            if (m_k == NL * NC) chk("ready_after_last", 64'(cfg_if.cfg_ready), 64'd0);
        end
        cfg_if.cfg_valid = 1'b0;
    endtask

    task automatic cyc(input logic [STAGE_WIDTH-1:0] st, input logic lcs);
        global_stage         = st;
        local_context_switch = lcs;
        @(posedge clk);
        m_out = m_ctx;
        if (m_stage == STAGE_WRITE_TO_MEM && !lcs) m_ctx = (m_ctx + 1) % NC;
        m_stage = st;
        @(negedge clk);
        chk("ctx", 64'(current_context), 64'(m_ctx));
        chk_outputs("ctx_out", m_out);
    endtask

    task automatic start_load();
        m_err = 1'b0;
        m_k   = 0;
        global_stage = STAGE_PARAMETERS_LOADING;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_ready"}, 64'(cfg_if.cfg_ready), 64'd0);
        chk({tag, "_done"},  64'(load_done), 64'd0);
        chk({tag, "_err"},   64'(cfg_error), 64'd0);
        chk({tag, "_ctx"},   64'(current_context), 64'd0);
        chk_outputs(tag, 0);
    endtask

    initial begin
        reset = 1'b1;
        global_stage = STAGE_IDLE;
        local_context_switch = 1'b0;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_data  = '0;
        model_reset_table();
        m_err = 1'b0;
        m_k = 0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_reset_state("reset");

        // Gap-free load of the deterministic pattern.
        start_load();
        load(NL * NC, 0, 0);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_data  = 4'b1001;
        repeat (4) begin
            @(negedge clk);
            chk("held_valid_ready", 64'(cfg_if.cfg_ready), 64'd0);
            chk("held_valid_done",  64'(load_done), 64'd1);
        end
        cfg_if.cfg_valid = 1'b0;
        chk("a_ctx", 64'(current_context), 64'd0);
        chk_outputs("a_ctx0", 0);
        chk("a_err", 64'(cfg_error), 64'(exp_err()));

        // Context stepping, then random context-switch holds.
        m_stage = STAGE_PARAMETERS_LOADING; m_ctx = 0; m_out = 0;
        repeat (4) cyc(STAGE_WRITE_TO_MEM, 1'b0);
        repeat (8) cyc(STAGE_WRITE_TO_MEM, 1'($urandom_range(0, 1)));
        repeat (2) cyc(STAGE_IDLE, 1'b0);
        repeat (3) cyc(STAGE_WRITE_TO_MEM, 1'b1);
        repeat (2) cyc(STAGE_COMPUTE, 1'b0);

        // Random words with gaps/bursts, illegal word first.
        start_load();
        load(NL * NC, 3, 2);
        chk("b_ctx", 64'(current_context), 64'd0);
        chk_outputs("b_ctx0", 0);
        chk("illegal_w",  64'(weight_out[LBW-1:0]), 64'd0);
        chk("illegal_bc", 64'(boundary_condition_out[1:0]), 64'd2);
        chk("b_err", 64'(cfg_error), 64'(exp_err()));
        m_stage = STAGE_PARAMETERS_LOADING; m_ctx = 0; m_out = 0;
        repeat (3) cyc(STAGE_WRITE_TO_MEM, 1'b0);
        repeat (2) cyc(STAGE_IDLE, 1'b0);

        // Abort after 5 words, then a full restart from word 0.
        start_load();
        load(5, 1, 1);
        global_stage = STAGE_IDLE;
        repeat (4) @(negedge clk);
        m_err = 1'b1;
        chk("abort_done",  64'(load_done), 64'd0);
        chk("abort_ready", 64'(cfg_if.cfg_ready), 64'd0);
        chk("abort_err",   64'(cfg_error), 64'(exp_err()));
        chk_outputs("abort_kept", 0);
        start_load();
        load(NL * NC, 2, 1);
        chk("c_err", 64'(cfg_error), 64'(exp_err()));
        chk_outputs("c_ctx0", 0);
        m_stage = STAGE_PARAMETERS_LOADING; m_ctx = 0; m_out = 0;
        repeat (3) cyc(STAGE_WRITE_TO_MEM, 1'b0);
        repeat (2) cyc(STAGE_IDLE, 1'b0);

        // Reset in the middle of a load.
        start_load();
        load(4, 0, 1);
        reset = 1'b1;
        global_stage = STAGE_IDLE;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset_table();
        m_err = 1'b0;
        @(negedge clk);
        check_reset_state("midreset");
        m_stage = STAGE_IDLE; m_ctx = 0; m_out = 0;
        repeat (3) cyc(STAGE_WRITE_TO_MEM, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
